trap_ctrl: RTL and testbench
============================

# trap_ctrl

Machine-mode trap sequencer. It is the initiator on the CSR file's exception port: it drives `save_epc`/`pc` into the CSR block and reads back `epc`. It arbitrates illegal-instruction, ecall, mret and external-interrupt events from the execute stage, flushes and stalls the pipeline, and issues a handshaked PC redirect to fetch: to the trap vector on entry, or to the saved EPC on return.

## Interface
- `MTVEC`, default 32'h0000_0100: fixed trap vector address.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid_i`  in  1  execute stage holds a valid instruction this cycle.
- `instr_pc_i`  in  32  PC of that instruction.
- `illegal_i`  in  1  instruction is illegal; qualified by `instr_valid_i`.
- `ecall_i`  in  1  instruction is ECALL; qualified by `instr_valid_i`.
- `mret_i`  in  1  instruction is MRET; qualified by `instr_valid_i`.
- `irq_i`  in  1  external interrupt, level-sensitive.
- `mie_i`  in  1  mstatus.MIE from the CSR file.
- `epc_i`  in  32  current mepc from the CSR file.
- `save_epc_o`  out  1  one-cycle pulse; the CSR file latches `pc_o` into mepc and stacks MIE.
- `pc_o`  out  32  EPC value to save.
- `mret_o`  out  1  one-cycle pulse; the CSR file restores MIE from MPIE.
- `cause_valid_o`  out  1  one-cycle pulse, coincident with `save_epc_o`.
- `cause_o`  out  32  mcause value.
- `flush_o`  out  1  kill all in-flight instructions.
- `stall_o`  out  1  freeze the pipeline.
- `redirect_valid_o`  out  1  redirect request to fetch.
- `redirect_pc_o`  out  32  redirect target.
- `redirect_ready_i`  in  1  fetch accepts the redirect.

## Operation
- States: IDLE, SAVE, MRET, REDIRECT.
- Event selection happens in IDLE only, with priority illegal > ecall > mret > irq.
  - Exceptions and mret count only when `instr_valid_i`=1.
  - irq is taken only when `irq_i & mie_i & instr_valid_i`. The interrupted instruction is not executed and its PC becomes the EPC.
- Accepting a trap (illegal, ecall or irq) in IDLE:
  - Latch `instr_pc_i` into the EPC register and the cause into the cause register.
  - Next state is SAVE.
- Cause codes: illegal = 32'd2; ecall = 32'd11; irq = 32'h8000_000B.
- SAVE:
  - `save_epc_o`=1, `cause_valid_o`=1, `pc_o` = latched EPC.
  - Load the target register with `MTVEC`.
  - Next state is REDIRECT.
- Accepting mret in IDLE: next state is MRET.
- MRET:
  - `mret_o`=1.
  - Load the target register with `epc_i` sampled this cycle.
  - Next state is REDIRECT.
- REDIRECT:
  - `redirect_valid_o`=1 and `redirect_pc_o` = target register. Both are held stable until `redirect_ready_i`=1.
  - Return to IDLE on the cycle after the handshake.
- Combinational outputs: `flush_o` = `stall_o` = (event accepted in IDLE) | (state != IDLE).
- Registered values: `pc_o`, `cause_o` and `redirect_pc_o` come from registers. Outside their valid strobes they hold their last value.
- Events arriving outside IDLE are ignored; the pipeline is flushed anyway.
  - A still-asserted, enabled irq is re-evaluated once IDLE is re-entered.
  - After a trap the CSR clears MIE, so `mie_i`=0 blocks nested irqs.
- Simultaneous illegal, ecall and irq: exactly one trap is taken, with the cause of the highest-priority event. No second save occurs.

## Timing
- Reset value of every output: 0. Registers reset to 0 and the state resets to IDLE.
- Reset asserted mid-sequence aborts it immediately. No pulse is completed after release.
- Trap event sampled at cycle T:
  - T+1: SAVE pulse.
  - T+2: `redirect_valid_o` rises.
  - If ready at T+2: IDLE at T+3, and a new event can be accepted at T+3.
- mret sampled at T:
  - T+1: `mret_o`, with `epc_i` sampled.
  - T+2: redirect to that value.
- Backpressure: each cycle of `redirect_ready_i`=0 in REDIRECT extends the sequence by one cycle. `stall_o` and `flush_o` remain high throughout.
- `save_epc_o`, `cause_valid_o` and `mret_o` are exactly one cycle wide and never overlap each other.

## Test plan
- Illegal at PC 0x0000_0040, ready tied 1:
  - T+1: `save_epc_o`=1, `pc_o`=0x40, `cause_o`=2.
  - T+2: `redirect_pc_o`=0x100.
  - T+3: IDLE, `stall_o`=0.
- Illegal, ecall and irq (mie=1) together at PC 0x80 -> a single save with `cause_o`=2 and exactly one redirect to 0x100.
- mret with `epc_i`=0x0000_0044:
  - T+1: `mret_o` pulse.
  - T+2: `redirect_pc_o`=0x44.
  - No `save_epc_o`.
- irq=1, mie=0 for 10 cycles -> no trap. Raising mie at PC 0x200 -> `cause_o`=0x8000_000B, `pc_o`=0x200.
- `redirect_ready_i` held 0 for 5 cycles -> `redirect_valid_o` and `redirect_pc_o` stable for 6 cycles. `stall_o`/`flush_o` stay high. IDLE follows one cycle after ready.
- `rst_n` pulsed low while in REDIRECT -> all outputs 0 asynchronously. After release: IDLE, with no save, mret or redirect emitted.

Source files
------------

// File: rtl/trap_ctrl.sv
// ----------------------------------------------------------------------------
// trap_ctrl -- machine-mode trap sequencer
//
// This block watches the execute stage and picks one event to handle, in the
// order illegal > ecall > mret > external interrupt. A trap saves the EPC and
// cause through the CSR exception port and then redirects fetch to MTVEC. An
// mret pulses the CSR restore and then redirects fetch to the mepc the CSR
// file reports. The pipeline is stalled and flushed from the cycle an event
// is accepted until the redirect handshake completes.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   instr_valid_i       execute stage holds a valid instruction
//   instr_pc_i          PC of that instruction
//   illegal_i/ecall_i/mret_i   instruction class, qualified by instr_valid_i
//   irq_i, mie_i        level interrupt request and mstatus.MIE
//   epc_i               current mepc from the CSR file
//   save_epc_o, pc_o    one-cycle save strobe and the EPC to save
//   mret_o              one-cycle MIE restore strobe
//   cause_valid_o, cause_o     mcause strobe (with save_epc_o) and value
//   flush_o, stall_o    kill in-flight instructions / freeze the pipeline
//   redirect_valid_o, redirect_pc_o, redirect_ready_i   fetch redirect handshake
// ----------------------------------------------------------------------------
module trap_ctrl #(
   parameter logic [31:0] MTVEC = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid_i,
   input  logic [31:0] instr_pc_i,
   input  logic        illegal_i,
   input  logic        ecall_i,
   input  logic        mret_i,
   input  logic        irq_i,
   input  logic        mie_i,
   input  logic [31:0] epc_i,
   output logic        save_epc_o,
   output logic [31:0] pc_o,
   output logic        mret_o,
   output logic        cause_valid_o,
   output logic [31:0] cause_o,
   output logic        flush_o,
   output logic        stall_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o,
   input  logic        redirect_ready_i
);

   localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
   localparam logic [31:0] CAUSE_ECALL   = 32'd11;
   localparam logic [31:0] CAUSE_IRQ     = 32'h8000_000B;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SAVE     = 2'd1,
      ST_MRET     = 2'd2,
      ST_REDIRECT = 2'd3
   } state_e;

   state_e      state_q;
   logic [31:0] epc_q;
   logic [31:0] cause_q;
   logic [31:0] target_q;
   logic        save_q;
   logic        mret_q;
   logic        redir_valid_q;

   logic        trap_take;
   logic        mret_take;
   logic [31:0] cause_d;

   // Event selection; only IDLE looks at the execute stage, so events that
   // arrive mid-sequence are dropped (the pipeline is being flushed anyway).
   always_comb begin
      // NOTE: every signal gets a default before the branches so no latch is inferred.
      trap_take = 1'b0;
      mret_take = 1'b0;
      cause_d   = cause_q;
      if (state_q == ST_IDLE && instr_valid_i) begin
         if (illegal_i) begin
            trap_take = 1'b1;
            cause_d   = CAUSE_ILLEGAL;
         end else if (ecall_i) begin
            trap_take = 1'b1;
            cause_d   = CAUSE_ECALL;
         end else if (mret_i) begin
            mret_take = 1'b1;
         end else if (irq_i && mie_i) begin
            trap_take = 1'b1;
            cause_d   = CAUSE_IRQ;
         end
      end
   end

   // Sequencer: strobes are registered and default low, so each is exactly
   // one cycle wide and the states that raise them are mutually exclusive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         epc_q         <= '0;
         cause_q       <= '0;
         target_q      <= '0;
         save_q        <= 1'b0;
         mret_q        <= 1'b0;
         redir_valid_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         save_q <= 1'b0;
         mret_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (trap_take) begin
                  epc_q   <= instr_pc_i;
                  cause_q <= cause_d;
                  save_q  <= 1'b1;
                  state_q <= ST_SAVE;
               end else if (mret_take) begin
                  mret_q  <= 1'b1;
                  state_q <= ST_MRET;
               end
            end
            ST_SAVE: begin
               target_q      <= MTVEC;
               redir_valid_q <= 1'b1;
               state_q       <= ST_REDIRECT;
            end
            ST_MRET: begin
               // epc_i is sampled while mret_o is high, i.e. before the CSR
               // file could be written by anything else.
               target_q      <= epc_i;
               redir_valid_q <= 1'b1;
               state_q       <= ST_REDIRECT;
            end
            ST_REDIRECT: begin
               if (redirect_ready_i) begin
                  redir_valid_q <= 1'b0;
                  state_q       <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign save_epc_o       = save_q;
   assign cause_valid_o    = save_q;
   assign pc_o             = epc_q;
   assign cause_o          = cause_q;
   assign mret_o           = mret_q;
   assign redirect_valid_o = redir_valid_q;
   assign redirect_pc_o    = target_q;

   // Stall/flush must cover the accepting cycle itself, hence the
   // combinational term on top of the state decode.
   assign flush_o = trap_take | mret_take | (state_q != ST_IDLE);
   assign stall_o = flush_o;

endmodule

// File: tb/tb_trap_ctrl.sv
// ----------------------------------------------------------------------------
// tb_trap_ctrl -- directed bench for trap_ctrl
//
// Expected CSR-port and redirect transactions are pushed to a scoreboard queue
// when the stimulus is driven; a negedge monitor pops and compares them when
// the DUT emits save/mret strobes or completes a redirect handshake. Cycle-
// exact directed checks are made from the stimulus block.
// ----------------------------------------------------------------------------
module tb_trap_ctrl;

   localparam logic [31:0] MTVEC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid_i;
   logic [31:0] instr_pc_i;
   logic        illegal_i;
   logic        ecall_i;
   logic        mret_i;
   logic        irq_i;
   logic        mie_i;
   logic [31:0] epc_i;
   logic        save_epc_o;
   logic [31:0] pc_o;
   logic        mret_o;
   logic        cause_valid_o;
   logic [31:0] cause_o;
   logic        flush_o;
   logic        stall_o;
   logic        redirect_valid_o;
   logic [31:0] redirect_pc_o;
   logic        redirect_ready_i;

   trap_ctrl #(.MTVEC(MTVEC)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .instr_valid_i    (instr_valid_i),
      .instr_pc_i       (instr_pc_i),
      .illegal_i        (illegal_i),
      .ecall_i          (ecall_i),
      .mret_i           (mret_i),
      .irq_i            (irq_i),
      .mie_i            (mie_i),
      .epc_i            (epc_i),
      .save_epc_o       (save_epc_o),
      .pc_o             (pc_o),
      .mret_o           (mret_o),
      .cause_valid_o    (cause_valid_o),
      .cause_o          (cause_o),
      .flush_o          (flush_o),
      .stall_o          (stall_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o),
      .redirect_ready_i (redirect_ready_i)
   );

   always #5 clk = ~clk;

   typedef enum logic [1:0] {EV_SAVE = 2'd0, EV_MRET = 2'd1, EV_REDIR = 2'd2} ev_e;
   typedef struct {
      ev_e         kind;
      logic [31:0] pc;
      logic [31:0] cause;
   } exp_t;

   exp_t sb_q[$];
   int   vectors    = 0;
   int   miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push(input ev_e kind, input logic [31:0] pc, input logic [31:0] cause);
      exp_t e;
      e.kind  = kind;
      e.pc    = pc;
      e.cause = cause;
      sb_q.push_back(e);
   endtask

   task automatic pop_check(input ev_e kind, input logic [31:0] pc, input logic [31:0] cause);
      exp_t e;
      if (sb_q.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL sb_unexpected: observed event %0d expected none", kind);
      end else begin
         e = sb_q.pop_front();
         check("sb_kind", 32'(kind), 32'(e.kind));
         if (e.kind == EV_SAVE) begin
            check("sb_save_pc", pc, e.pc);
            check("sb_save_cause", cause, e.cause);
         end else if (e.kind == EV_REDIR) begin
            check("sb_redir_pc", pc, e.pc);
         end
      end
   endtask

   // Scoreboard monitor: consumes one expectation per observed transaction.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (save_epc_o || cause_valid_o || mret_o) begin
            check("cause_valid_eq_save", 32'(cause_valid_o), 32'(save_epc_o));
            check("strobe_overlap", 32'(save_epc_o & mret_o), 32'd0);
         end
         if (save_epc_o) pop_check(EV_SAVE, pc_o, cause_o);
         if (mret_o) pop_check(EV_MRET, 32'd0, 32'd0);
         if (redirect_valid_o && redirect_ready_i) pop_check(EV_REDIR, redirect_pc_o, 32'd0);
      end
   end

   // Inputs change 1 time unit after the rising edge; checks run on the
   // falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      instr_valid_i = 1'b0;
      illegal_i     = 1'b0;
      ecall_i       = 1'b0;
      mret_i        = 1'b0;
      irq_i         = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n            = 1'b0;
      idle_inputs();
      instr_pc_i       = '0;
      mie_i            = 1'b0;
      epc_i            = '0;
      redirect_ready_i = 1'b1;
      #12;
      // ---- reset state
      check("rst_save", 32'(save_epc_o), 32'd0);
      check("rst_redir_valid", 32'(redirect_valid_o), 32'd0);
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_cause", cause_o, 32'd0);
      check("rst_pc", pc_o, 32'd0);
      check("rst_redir_pc", redirect_pc_o, 32'd0);
      #10 rst_n = 1'b1;

      // ---- illegal at 0x40, ready tied high
      tick();
      instr_valid_i = 1'b1; illegal_i = 1'b1; instr_pc_i = 32'h40;
      push(EV_SAVE, 32'h40, 32'd2);
      push(EV_REDIR, MTVEC, 32'd0);
      settle();
      check("ill_T_stall", 32'(stall_o), 32'd1);
      check("ill_T_flush", 32'(flush_o), 32'd1);
      tick(); idle_inputs(); settle();
      check("ill_T1_save", 32'(save_epc_o), 32'd1);
      check("ill_T1_pc", pc_o, 32'h40);
      check("ill_T1_cause", cause_o, 32'd2);
      tick(); settle();
      check("ill_T2_valid", 32'(redirect_valid_o), 32'd1);
      check("ill_T2_rpc", redirect_pc_o, MTVEC);
      check("ill_T2_save", 32'(save_epc_o), 32'd0);
      tick(); settle();
      check("ill_T3_stall", 32'(stall_o), 32'd0);
      check("ill_T3_valid", 32'(redirect_valid_o), 32'd0);
      check("ill_T3_cause_hold", cause_o, 32'd2);

      // ---- illegal + ecall + irq together at 0x80: one save, cause 2
      tick();
      instr_valid_i = 1'b1; illegal_i = 1'b1; ecall_i = 1'b1; irq_i = 1'b1;
      mie_i = 1'b1; instr_pc_i = 32'h80;
      push(EV_SAVE, 32'h80, 32'd2);
      push(EV_REDIR, MTVEC, 32'd0);
      tick(); idle_inputs(); mie_i = 1'b0; settle();
      check("multi_cause", cause_o, 32'd2);
      check("multi_pc", pc_o, 32'h80);
      for (int i = 0; i < 4; i++) tick();
      settle();
      check("multi_drained", 32'(sb_q.size()), 32'd0);

      // ---- mret with epc 0x44
      tick();
      instr_valid_i = 1'b1; mret_i = 1'b1; instr_pc_i = 32'h90; epc_i = 32'h44;
      push(EV_MRET, 32'd0, 32'd0);
      push(EV_REDIR, 32'h44, 32'd0);
      tick(); idle_inputs(); settle();
      check("mret_T1_pulse", 32'(mret_o), 32'd1);
      check("mret_T1_nosave", 32'(save_epc_o), 32'd0);
      tick(); epc_i = 32'hDEAD_0000; settle();
      check("mret_T2_valid", 32'(redirect_valid_o), 32'd1);
      check("mret_T2_rpc", redirect_pc_o, 32'h44);
      check("mret_T2_pulse", 32'(mret_o), 32'd0);
      tick(); settle();
      check("mret_T3_stall", 32'(stall_o), 32'd0);

      // ---- irq held with mie=0: no trap; then enable at 0x200
      for (int i = 0; i < 10; i++) begin
         tick();
         instr_valid_i = 1'b1; irq_i = 1'b1; mie_i = 1'b0;
         instr_pc_i = 32'h180 + 32'(i * 4);
         settle();
         check("irq_masked_stall", 32'(stall_o), 32'd0);
      end
      tick();
      mie_i = 1'b1; instr_pc_i = 32'h200;
      push(EV_SAVE, 32'h200, 32'h8000_000B);
      push(EV_REDIR, MTVEC, 32'd0);
      tick(); mie_i = 1'b0; instr_valid_i = 1'b0; settle();
      check("irq_cause", cause_o, 32'h8000_000B);
      check("irq_pc", pc_o, 32'h200);
      tick(); irq_i = 1'b0;
      tick(); settle();
      check("irq_idle", 32'(stall_o), 32'd0);

      // ---- ecall at 0x300 with 5 cycles of backpressure
      tick();
      instr_valid_i = 1'b1; ecall_i = 1'b1; instr_pc_i = 32'h300;
      redirect_ready_i = 1'b0;
      push(EV_SAVE, 32'h300, 32'd11);
      push(EV_REDIR, MTVEC, 32'd0);
      tick(); idle_inputs(); settle();
      check("bp_cause", cause_o, 32'd11);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 5) redirect_ready_i = 1'b1;
         // An event arriving mid-sequence must be ignored.
         if (i == 2) begin instr_valid_i = 1'b1; illegal_i = 1'b1; end
         else idle_inputs();
         settle();
         check("bp_valid", 32'(redirect_valid_o), 32'd1);
         check("bp_rpc", redirect_pc_o, MTVEC);
         check("bp_stall", 32'(stall_o), 32'd1);
         check("bp_flush", 32'(flush_o), 32'd1);
      end
      tick(); settle();
      check("bp_idle_stall", 32'(stall_o), 32'd0);
      check("bp_idle_valid", 32'(redirect_valid_o), 32'd0);

      // ---- reset asserted while in REDIRECT
      tick();
      instr_valid_i = 1'b1; illegal_i = 1'b1; instr_pc_i = 32'h500;
      redirect_ready_i = 1'b0;
      push(EV_SAVE, 32'h500, 32'd2);
      tick(); idle_inputs();
      tick(); settle();
      check("rstmid_valid_before", 32'(redirect_valid_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_valid", 32'(redirect_valid_o), 32'd0);
      check("rstmid_rpc", redirect_pc_o, 32'd0);
      check("rstmid_pc", pc_o, 32'd0);
      check("rstmid_cause", cause_o, 32'd0);
      check("rstmid_stall", 32'(stall_o), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      redirect_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(); settle();
         check("rstpost_save", 32'(save_epc_o), 32'd0);
         check("rstpost_mret", 32'(mret_o), 32'd0);
         check("rstpost_valid", 32'(redirect_valid_o), 32'd0);
      end

      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
